// File: rtl/sram_controller_if.sv
// MEM-stage request bus of the SRAM bridge: load/store request in, load
// result and ready (pipeline freeze release) out.
interface sram_controller_if;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;

    // Pipeline side issues requests
    modport master (
        output wr_en, rd_en, address, write_data,
        input  read_data, ready
    );

    // Controller side services requests
    modport slave (
        input  wr_en, rd_en, address, write_data,
        output read_data, ready
    );
endinterface

// File: rtl/sram_controller.sv
// Multi-cycle bridge from the MEM stage to a 16-bit asynchronous SRAM.
// Each 32-bit access becomes a low and a high half-word phase, each lasting
// WAIT_CYCLES clocks; ready stays low (pipeline frozen) until the word is done.
// Optional feature: define SRAM_READ_HIT_EN to remember the last word read and
// answer a repeated read of it in the same cycle without touching the SRAM.
module sram_controller #(
    parameter logic [31:0] ADDR_BASE   = 32'd1024,
    parameter int          SRAM_AW     = 18,
    parameter int          WAIT_CYCLES = 1
) (
    input  logic               clk,
    input  logic               rst,
    sram_controller_if.slave   bus,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [15:0]        sram_dq_out,
    input  logic [15:0]        sram_dq_in,
    output logic               sram_dq_oe,
    output logic               sram_we_n
);

    localparam int              CW       = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(WAIT_CYCLES - 1);
    localparam int              WW       = SRAM_AW - 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOW  = 2'd1;
    localparam logic [1:0] S_HIGH = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               is_write_q, is_write_d;
    logic [WW-1:0]      word_q, word_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        rdata_q, rdata_d;
    logic [SRAM_AW-1:0] addr_q, addr_d;
    logic [15:0]        dq_out_q, dq_out_d;
    logic               oe_q, oe_d;
    logic               we_n_q, we_n_d;

    logic [31:0]        adr;
    logic [WW-1:0]      req_word;
    logic               req;
    logic               hit;
    logic               start;
    logic               last;
    logic               unused_adr_bits;

    // Offset into SRAM space (wraps freely) and request decode
    assign adr             = bus.address - ADDR_BASE;
    assign req_word        = adr[SRAM_AW:2];
    assign unused_adr_bits = ^{adr[31:SRAM_AW+1], adr[1:0]};
    assign req             = bus.wr_en | bus.rd_en;
    assign start           = req & ~hit;
    assign last            = (cnt_q == CNT_LAST);

`ifdef SRAM_READ_HIT_EN
    logic [WW-1:0] tag_q, tag_d;
    logic          valid_q, valid_d;

    assign hit = bus.rd_en & ~bus.wr_en & valid_q & (req_word == tag_q);

    // Track the last word read; any write invalidates it
    always_comb begin
        tag_d   = tag_q;
        valid_d = valid_q;
        if (state_q == S_IDLE && start && bus.wr_en) begin
            valid_d = 1'b0;
        end
        if (state_q == S_HIGH && last && !is_write_q) begin
            tag_d   = word_q;
            valid_d = 1'b1;
        end
    end

    // Tag storage
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            tag_q   <= tag_d;
            valid_q <= valid_d;
        end
    end
`else
    assign hit = 1'b0;
`endif

    // Access sequencing: latch the request in IDLE, then low and high phases
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        is_write_d = is_write_q;
        word_d     = word_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    is_write_d = bus.wr_en;
                    word_d     = req_word;
                    wdata_d    = bus.write_data;
                    cnt_d      = '0;
                    state_d    = S_LOW;
                end
            end
            S_LOW: begin
                if (last) begin
                    if (!is_write_q) begin
                        rdata_d[15:0] = sram_dq_in;
                    end
                    cnt_d   = '0;
                    state_d = S_HIGH;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_HIGH: begin
                if (last) begin
                    if (!is_write_q) begin
                        rdata_d[31:16] = sram_dq_in;
                    end
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // SRAM pins are registered from the next state so they line up with the
    // phase the state register is in; address and data hold between accesses
    always_comb begin
        addr_d   = addr_q;
        dq_out_d = dq_out_q;
        oe_d     = 1'b0;
        we_n_d   = 1'b1;
        case (state_d)
            S_LOW: begin
                addr_d = {word_d, 1'b0};
                if (is_write_d) begin
                    oe_d     = 1'b1;
                    we_n_d   = 1'b0;
                    dq_out_d = wdata_d[15:0];
                end
            end
            S_HIGH: begin
                addr_d = {word_d, 1'b1};
                if (is_write_d) begin
                    oe_d     = 1'b1;
                    we_n_d   = 1'b0;
                    dq_out_d = wdata_d[31:16];
                end
            end
            default: begin
            end
        endcase
    end

    // State and pin registers; reset aborts any access in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            is_write_q <= 1'b0;
            word_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            addr_q     <= '0;
            dq_out_q   <= '0;
            oe_q       <= 1'b0;
            we_n_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            is_write_q <= is_write_d;
            word_q     <= word_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            addr_q     <= addr_d;
            dq_out_q   <= dq_out_d;
            oe_q       <= oe_d;
            we_n_q     <= we_n_d;
        end
    end

    assign bus.ready     = (state_q == S_DONE) | ((state_q == S_IDLE) & ~start);
    assign bus.read_data = rdata_q;
    assign sram_addr     = addr_q;
    assign sram_dq_out   = dq_out_q;
    assign sram_dq_oe    = oe_q;
    assign sram_we_n     = we_n_q;

endmodule
